// File: rtl/fetch_unit.sv
// fetch_unit: decoupled fetch front end owning the PC, issuing word requests
// to a variable-latency instruction memory and buffering responses in a
// DEPTH-entry prefetch FIFO that feeds decode.
// Ports: clk, rst (async, active low), fetch_en,
//        imem_req_{valid,ready,addr}, imem_rsp_{valid,data},
//        inst_{valid,ready,data,pc}, redirect_{valid,pc}.
// Define FETCH_PERF_EN to add perf_fetched/perf_dropped/perf_stall counters.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW:0]     outstanding;
  logic [CW:0]     drop;
  logic [CW:0]     count;
  logic [CW-1:0]   tag_wr;
  logic [CW-1:0]   tag_rd;
  logic [CW-1:0]   fifo_wr;
  logic [CW-1:0]   fifo_rd;

  logic [XLEN-1:0] tag_q  [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [31:0]     data_q [DEPTH];

  logic [CW+2:0] used;
  logic          credit;
  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          unused;

  assign unused = ^redirect_pc[1:0];

  // Every slot that may still be filled counts against the FIFO,
  // including responses already marked for discard.
  assign used = {2'b00, outstanding}
              + {2'b00, count}
              + {2'b00, drop};
  assign credit = used < (CW+3)'(DEPTH);

  assign imem_req_valid = (state == RUN) & credit & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid & (drop != '0);
  assign rsp_keep = imem_rsp_valid & (drop == '0);
  assign push     = rsp_keep & ~redirect_valid;

  assign inst_valid = count != '0;
  assign pop        = inst_valid & inst_ready;
  assign inst_pc    = inst_valid ? pc_q[fifo_rd] : '0;
  assign inst_data  = inst_valid ? data_q[fifo_rd] : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else begin
      state <= fetch_en ? RUN : IDLE;
      if (redirect_valid) begin
        fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        // Everything still in flight becomes garbage; a response
        // landing now is consumed from that total either way.
        drop        <= drop + outstanding
                     - {{CW{1'b0}}, imem_rsp_valid};
        outstanding <= '0;
        count       <= '0;
        tag_wr      <= '0;
        tag_rd      <= '0;
        fifo_wr     <= '0;
        fifo_rd     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tag_wr   <= tag_wr + CW'(1);
        end
        if (rsp_keep) begin
          tag_rd  <= tag_rd + CW'(1);
          fifo_wr <= fifo_wr + CW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + CW'(1);
        end
        outstanding <= outstanding
                     + {{CW{1'b0}}, req_fire}
                     - {{CW{1'b0}}, rsp_keep};
        drop  <= drop - {{CW{1'b0}}, rsp_drop};
        count <= count
               + {{CW{1'b0}}, push}
               - {{CW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[tag_wr] <= fetch_pc;
    end
    if (push) begin
      pc_q[fifo_wr]   <= tag_q[tag_rd];
      data_q[fifo_wr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (rsp_drop || (rsp_keep && redirect_valid)) begin
        perf_dropped <= perf_dropped + 32'd1;
      end
      if (state == RUN && !req_fire) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Memory must never answer a request it was not given.
  a_rsp_legal: assert property (
    @(posedge clk) disable iff (!rst)
    rsp_keep |-> (outstanding != '0 &&
                  count != (CW+1)'(DEPTH)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit against a
// queue-based reference model of the fetch stream and memory.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
  logic [31:0] w_pf, w_pd, w_ps;
`endif

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped),
    .perf_stall(perf_stall)
`endif
  );

  // Second instance: reset vector near the top of the address space.
  logic        w_req_valid, w_inst_valid;
  logic [31:0] w_addr, w_inst_data, w_inst_pc;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_d = '0;
  logic [31:0] wseen[$];

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst), .fetch_en(1'b1),
    .imem_req_valid(w_req_valid),
    .imem_req_ready(1'b1),
    .imem_req_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(1'b1),
    .inst_data(w_inst_data), .inst_pc(w_inst_pc),
    .redirect_valid(1'b0),
    .redirect_pc(32'd0)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_pf),
    .perf_dropped(w_pd),
    .perf_stall(w_ps)
`endif
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        memq[$];
  logic [31:0] mfifo[$];
  logic [31:0] seen[$];
  logic [31:0] reqs[$];
  bit          run = 1'b0;
  logic [31:0] req_pc = '0;
  int          epoch = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          exp_rv;
  bit          keep;
  int          due;
  req_t        e;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      memq.delete();
      mfifo.delete();
      run = 1'b0;
      req_pc = 32'h0;
      last_due = 0;
    end
    if (rst && memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    #1;
    exp_rv = run && (memq.size() + mfifo.size() < DEPTH) && !redirect_valid;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    chk("req_addr", imem_req_addr, req_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, mfifo.size() != 0});
    chk("inst_pc", inst_pc, mfifo.size() != 0 ? mfifo[0] : 32'h0);
    chk("inst_data", inst_data,
        mfifo.size() != 0 ? mem_word(mfifo[0]) : 32'h0);
    if (rst) begin
      if (inst_valid && inst_ready) seen.push_back(inst_pc);
      if (imem_req_valid && imem_req_ready) reqs.push_back(imem_req_addr);
      if (mfifo.size() != 0 && inst_ready) void'(mfifo.pop_front());
      keep = 1'b0;
      if (imem_rsp_valid) begin
        e = memq.pop_front();
        keep = (e.ep == epoch) && !redirect_valid;
      end
      if (redirect_valid) begin
        mfifo.delete();
        epoch++;
        req_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (keep) mfifo.push_back(e.addr);
        if (exp_rv && imem_req_ready) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          memq.push_back('{addr: req_pc, due: due, ep: epoch});
          req_pc = req_pc + 32'd4;
        end
      end
      run = fetch_en;
    end
    cyc++;
  end

  // One-cycle memory for the wrap instance.
  always @(negedge clk) begin
    #1;
    w_rsp_valid = w_pend && rst;
    w_rsp_data = w_pend_d;
    #1;
    if (!rst) begin
      w_pend = 1'b0;
    end else begin
      w_pend = w_req_valid;
      w_pend_d = mem_word(w_addr);
      if (w_inst_valid && wseen.size() < 3) wseen.push_back(w_inst_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    go(2);
    seen.delete();
    reqs.delete();
  endtask

  task automatic wait_seen(input int n, input int budget, input string name);
    for (int k = 0; k < budget && seen.size() < n; k++) @(negedge clk);
    chk(name, {31'd0, seen.size() >= n}, 32'd1);
  endtask

  int          first;
  logic [31:0] f_pc, f_data;
  bit          found;
  int          n20, idx;

  initial begin
    #2 rst = 1'b0;
    go(2);

    // Streaming from reset with a 1-cycle memory.
    fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    lat_min = 1; lat_max = 1;
    seen.delete(); reqs.delete();
    rst = 1'b1;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      #3;
      if (first < 0 && inst_valid) begin
        first = k; f_pc = inst_pc; f_data = inst_data;
      end
      @(negedge clk);
    end
    chk("t1_latency", 32'(first), 32'd3);
    chk("t1_pc", f_pc, 32'h0);
    chk("t1_data", f_data, 32'hA5A5_0000);
    chk("t1_count", 32'(seen.size()), 32'd5);
    chk("t1_seq3", qat(seen, 3), 32'hC);
    chk("t1_req4", qat(reqs, 4), 32'h10);
    chk("t5_wrap0", qat(wseen, 0), 32'hFFFF_FFF8);
    chk("t5_wrap1", qat(wseen, 1), 32'hFFFF_FFFC);
    chk("t5_wrap2", qat(wseen, 2), 32'h0000_0000);

    // Decode stalled: FIFO fills, then drains in order.
    do_reset();
    inst_ready = 1'b0;
    rst = 1'b1;
    go(12);
    #3;
    chk("t2_reqs", 32'(reqs.size()), 32'd4);
    chk("t2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_inst_valid", {31'd0, inst_valid}, 32'd1);
    @(negedge clk);
    inst_ready = 1'b1;
    go(8);
    chk("t2_pc0", qat(seen, 0), 32'h0);
    chk("t2_pc1", qat(seen, 1), 32'h4);
    chk("t2_pc2", qat(seen, 2), 32'h8);
    chk("t2_pc3", qat(seen, 3), 32'hC);
    chk("t2_resume", qat(reqs, 4), 32'h10);

    // Redirect with three requests in flight on a 3-cycle memory.
    do_reset();
    lat_min = 3; lat_max = 3;
    rst = 1'b1;
    go(4);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #3;
    chk("t3_inflight", 32'(reqs.size()), 32'd3);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_seen(1, 20, "t3_timeout");
    chk("t3_pc", qat(seen, 0), 32'h100);
    chk("t3_req", qat(reqs, 3), 32'h100);
`ifdef FETCH_PERF_EN
    chk("t3_perf_dropped", perf_dropped, 32'd3);
`endif

    // Redirect coinciding with a handshake at 0x20.
    do_reset();
    lat_min = 1; lat_max = 1;
    rst = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      #3;
      if (inst_valid && inst_pc == 32'h1C) found = 1'b1;
    end
    chk("t4_found", {31'd0, found}, 32'd1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_seen(12, 30, "t4_timeout");
    n20 = 0; idx = -1;
    foreach (seen[i]) if (seen[i] == 32'h20) begin n20++; idx = i; end
    chk("t4_once", 32'(n20), 32'd1);
    chk("t4_next", qat(seen, idx + 1), 32'h200);

    // Reset with two requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    rst = 1'b1;
    go(3);
    rst = 1'b0;
    #3;
    chk("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
    go(2);
    seen.delete(); reqs.delete();
    rst = 1'b1;
    wait_seen(2, 20, "t6_timeout");
    chk("t6_req0", qat(reqs, 0), 32'h0);
    chk("t6_pc0", qat(seen, 0), 32'h0);
    chk("t6_pc1", qat(seen, 1), 32'h4);

    // Randomized traffic.
    do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) begin
        lat_min = 1; lat_max = 1 + (i / 1000);
      end
      fetch_en = $urandom_range(9, 0) != 0;
      imem_req_ready = $urandom_range(3, 0) != 0;
      inst_ready = $urandom_range(3, 0) != 0;
      redirect_valid = $urandom_range(24, 0) == 0;
      redirect_pc = ($urandom_range(5, 0) == 0)
                  ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                  : $urandom;
      rst = $urandom_range(399, 0) != 0;
    end
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0;
    go(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
